// File: rtl/aes_stream_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_stream_arbiter_if
// Description : Requester and encrypter handshake bundle for aes_stream_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_stream_arbiter_if #(
    parameter int NONCE_W = 96,
    parameter int CTR_W   = 32,
    parameter int BLK_W   = 8
);
    logic               req_j;
    logic               req_t;
    logic [NONCE_W-1:0] nonce_j;
    logic [NONCE_W-1:0] nonce_t;
    logic [BLK_W-1:0]   blocks_j;
    logic [BLK_W-1:0]   blocks_t;
    logic [127:0]       ks_data;
    logic               ks_valid_j;
    logic               ks_valid_t;
    logic               done_j;
    logic               done_t;
    logic               err_j;
    logic               err_t;
    logic               busy;
    logic               aes_reset;
    logic               aes_start;
    logic [NONCE_W-1:0] aes_nonce;
    logic [CTR_W-1:0]   aes_ctr;
    logic [1:0]         aes_sel;
    logic               aes_take;
    logic               aes_done;
    logic [127:0]       aes_stream;

    // Requesters plus encrypter side
    modport master (
        output req_j, req_t, nonce_j, nonce_t, blocks_j, blocks_t,
        output aes_done, aes_stream,
        input  ks_data, ks_valid_j, ks_valid_t, done_j, done_t, err_j, err_t, busy,
        input  aes_reset, aes_start, aes_nonce, aes_ctr, aes_sel, aes_take
    );

    // Arbiter side
    modport slave (
        input  req_j, req_t, nonce_j, nonce_t, blocks_j, blocks_t,
        input  aes_done, aes_stream,
        output ks_data, ks_valid_j, ks_valid_t, done_j, done_t, err_j, err_t, busy,
        output aes_reset, aes_start, aes_nonce, aes_ctr, aes_sel, aes_take
    );
endinterface
`default_nettype wire

// File: rtl/aes_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_stream_arbiter
// Description : Round-robin sharing of one AES-CTR encrypter between JAWNY/TAJNY.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_stream_arbiter #(
    parameter int         NONCE_W = 96,
    parameter int         CTR_W   = 32,
    parameter int         BLK_W   = 8,
    parameter int         TIMEOUT = 1024,
    parameter logic [1:0] KEY_J   = 2'd0,
    parameter logic [1:0] KEY_T   = 2'd1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    aes_stream_arbiter_if.slave bus
);

    localparam int   CNT_W = $clog2(TIMEOUT + 1);
    localparam logic OWN_J = 1'b0;
    localparam logic OWN_T = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_DELIVER = 3'd3,
        S_DONE    = 3'd4,
        S_ABORT   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic               silent_q, silent_d;
    logic [BLK_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [1:0]         sel_q, sel_d;
    logic [127:0]       ks_data_q, ks_data_d;

    logic               w_grant_t;
    logic [BLK_W-1:0]   w_blk;
    logic               w_req_own;
    logic               w_deliver;

    assign w_req_own = (owner_q == OWN_T) ? bus.req_t : bus.req_j;
    // A block whose owner has dropped its request is consumed but never delivered
    assign w_deliver = (state_q == S_DELIVER) && w_req_own;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        silent_d     = silent_q;
        remaining_d  = remaining_q;
        wait_cnt_d   = wait_cnt_q;
        nonce_d      = nonce_q;
        ctr_d        = ctr_q;
        sel_d        = sel_q;
        ks_data_d    = ks_data_q;
        w_grant_t    = bus.req_t && (!bus.req_j || (last_owner_q == OWN_J));
        w_blk        = w_grant_t ? bus.blocks_t : bus.blocks_j;

        case (state_q)
            S_IDLE: begin
                if (bus.req_j || bus.req_t) begin
                    owner_d     = w_grant_t ? OWN_T : OWN_J;
                    nonce_d     = w_grant_t ? bus.nonce_t : bus.nonce_j;
                    sel_d       = w_grant_t ? KEY_T : KEY_J;
                    remaining_d = w_blk;
                    ctr_d       = CTR_W'(1);
                    silent_d    = 1'b0;
                    state_d     = (w_blk == '0) ? S_ABORT : S_START;
                end
            end
            S_START: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.aes_done) begin
                    ks_data_d = bus.aes_stream;
                    state_d   = S_DELIVER;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DELIVER: begin
                remaining_d = remaining_q - BLK_W'(1);
                if (!w_req_own) begin
                    silent_d = 1'b1;
                    state_d  = S_ABORT;
                end else if (remaining_q == BLK_W'(1)) begin
                    state_d = S_DONE;
                end else if (&ctr_q) begin
                    // Refuse to wrap the counter: keystream reuse would follow
                    state_d = S_ABORT;
                end else begin
                    ctr_d   = ctr_q + CTR_W'(1);
                    state_d = S_START;
                end
            end
            S_DONE: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            S_ABORT: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_J;
            last_owner_q <= OWN_T;
            silent_q     <= 1'b0;
            remaining_q  <= '0;
            wait_cnt_q   <= '0;
            nonce_q      <= '0;
            ctr_q        <= '0;
            sel_q        <= '0;
            ks_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            silent_q     <= silent_d;
            remaining_q  <= remaining_d;
            wait_cnt_q   <= wait_cnt_d;
            nonce_q      <= nonce_d;
            ctr_q        <= ctr_d;
            sel_q        <= sel_d;
            ks_data_q    <= ks_data_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.aes_start  = (state_q == S_START);
    assign bus.aes_take   = (state_q == S_DELIVER);
    assign bus.aes_reset  = (state_q == S_ABORT);
    assign bus.aes_nonce  = nonce_q;
    assign bus.aes_ctr    = ctr_q;
    assign bus.aes_sel    = sel_q;
    assign bus.ks_data    = ks_data_q;
    assign bus.ks_valid_j = w_deliver && (owner_q == OWN_J);
    assign bus.ks_valid_t = w_deliver && (owner_q == OWN_T);
    assign bus.done_j     = (state_q == S_DONE) && (owner_q == OWN_J);
    assign bus.done_t     = (state_q == S_DONE) && (owner_q == OWN_T);
    assign bus.err_j      = (state_q == S_ABORT) && !silent_q && (owner_q == OWN_J);
    assign bus.err_t      = (state_q == S_ABORT) && !silent_q && (owner_q == OWN_T);

endmodule
`default_nettype wire

// File: tb/tb_aes_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aes_stream_arbiter
// Description : Scoreboard bench for aes_stream_arbiter with a behavioural encrypter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_stream_arbiter;
    localparam int NW  = 96;
    localparam int LAT = 4;
    localparam int TMO = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_stream_arbiter_if #(.NONCE_W(NW), .CTR_W(32), .BLK_W(8)) b  ();
    aes_stream_arbiter_if #(.NONCE_W(NW), .CTR_W(2),  .BLK_W(8)) b2 ();

    aes_stream_arbiter #(.NONCE_W(NW), .CTR_W(32), .BLK_W(8), .TIMEOUT(TMO),
                         .KEY_J(2'd0), .KEY_T(2'd1))
        dut (.clk(clk), .rst(rst), .bus(b.slave));

    aes_stream_arbiter #(.NONCE_W(NW), .CTR_W(2), .BLK_W(8), .TIMEOUT(64),
                         .KEY_J(2'd0), .KEY_T(2'd1))
        dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] ks_fn(input logic [95:0] n, input logic [31:0] c,
                                            input logic [1:0] s);
        return {n, c} ^ {4{30'd0, s}};
    endfunction

    // Scoreboard: kind 0 = block, 1 = done, 2 = err
    typedef struct {
        int           kind;
        bit           own;
        logic [127:0] data;
    } ev_t;
    ev_t sb[$];

    task automatic push(input int kind, input bit own, input logic [127:0] data);
        ev_t e;
        e.kind = kind; e.own = own; e.data = data;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input bit own, input logic [127:0] data);
        ev_t e;
        if (sb.size() == 0) begin
            check("sb_expected_event", 128'(sb.size()), 128'(1));
        end else begin
            e = sb.pop_front();
            check("sb_kind_owner", 128'({kind, own}), 128'({e.kind, e.own}));
            if (kind == 0) check("sb_block_data", data, e.data);
        end
    endtask

    // Behavioural encrypters: aes_done LAT cycles after aes_start
    int dly   = -1;
    int dly2  = -1;
    bit hang  = 1'b0;
    int n_start = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dly          <= -1;
            b.aes_done   <= 1'b0;
            b.aes_stream <= '0;
        end else begin
            b.aes_done <= 1'b0;
            if (b.aes_start) begin
                dly     <= LAT - 2;
                n_start <= n_start + 1;
            end else if (dly > 0) begin
                dly <= dly - 1;
            end else if (dly == 0) begin
                dly <= -1;
                if (!hang) begin
                    b.aes_done   <= 1'b1;
                    b.aes_stream <= ks_fn(b.aes_nonce, b.aes_ctr, b.aes_sel);
                end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dly2          <= -1;
            b2.aes_done   <= 1'b0;
            b2.aes_stream <= '0;
        end else begin
            b2.aes_done <= 1'b0;
            if (b2.aes_start) dly2 <= LAT - 2;
            else if (dly2 > 0) dly2 <= dly2 - 1;
            else if (dly2 == 0) begin
                dly2        <= -1;
                b2.aes_done <= 1'b1;
            end
        end
    end

    int n2_ks = 0, n2_done = 0, n2_err = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (b.ks_valid_j && b.ks_valid_t) check("ks_overlap", 128'(b.ks_valid_t), 128'(0));
            if (b.ks_valid_j || b.ks_valid_t) sb_pop(0, b.ks_valid_t, b.ks_data);
            if (b.done_j || b.done_t)         sb_pop(1, b.done_t, '0);
            if (b.err_j || b.err_t)           sb_pop(2, b.err_t, '0);
            if (b2.ks_valid_j) begin
                check("ctr2_value", 128'(b2.aes_ctr), 128'(n2_ks + 1));
                n2_ks++;
            end
            if (b2.done_j) n2_done++;
            if (b2.err_j)  n2_err++;
        end
    end

    task automatic wait_end(input bit own, input int lim);
        int n = 0;
        @(negedge clk);
        while (!(own ? (b.done_t || b.err_t) : (b.done_j || b.err_j)) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(own ? "end_seen_t" : "end_seen_j", 128'(n < lim), 128'(1));
        if (own) b.req_t = 1'b0;
        else     b.req_j = 1'b0;
    endtask

    task automatic wait_start(input int lim);
        int n = 0;
        @(negedge clk);
        while (!b.aes_start && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 128'(b.aes_start), 128'(1));
    endtask

    function automatic logic [127:0] out_vec();
        return 128'({b.busy, b.aes_start, b.aes_reset, b.aes_take, b.ks_valid_j, b.ks_valid_t,
                     b.done_j, b.done_t, b.err_j, b.err_t, b.aes_sel});
    endfunction

    initial begin
        logic [95:0] n1, n2;
        int s0, n;
        b.req_j = 0;  b.req_t = 0;  b.nonce_j = '0; b.nonce_t = '0;
        b.blocks_j = '0; b.blocks_t = '0;
        b2.req_j = 0; b2.req_t = 0; b2.nonce_j = '0; b2.nonce_t = '0;
        b2.blocks_j = '0; b2.blocks_t = '0;
        repeat (3) @(negedge clk);
        check("rst_strobes", out_vec(), '0);
        check("rst_ctr", 128'(b.aes_ctr), '0);
        check("rst_nonce", 128'(b.aes_nonce), '0);
        check("rst_ks_data", b.ks_data, '0);
        rst = 1'b0;
        @(negedge clk);

        // Three-block JAWNY job
        n1 = {12{8'hA5}};
        @(posedge clk); #1;
        b.nonce_j = n1; b.blocks_j = 8'd3; b.req_j = 1'b1;
        for (int k = 1; k <= 3; k++) push(0, 1'b0, ks_fn(n1, k, 2'd0));
        push(1, 1'b0, '0);
        s0 = n_start;
        @(negedge clk);
        check("t1_no_start_at_grant", 128'(b.aes_start), 128'(0));
        @(negedge clk);
        check("t1_start_latency", 128'(b.aes_start), 128'(1));
        check("t1_sel", 128'(b.aes_sel), 128'(0));
        check("t1_ctr", 128'(b.aes_ctr), 128'(1));
        check("t1_nonce", 128'(b.aes_nonce), 128'(n1));
        wait_end(1'b0, 200);
        check("t1_start_count", 128'(n_start - s0), 128'(3));
        @(negedge clk);
        check("t1_busy_low", 128'(b.busy), 128'(0));

        // Simultaneous requests straight after reset: JAWNY first
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        n1 = 96'h1111_2222_3333_4444_5555_6666;
        n2 = 96'h9999_8888_7777_6666_5555_4444;
        @(posedge clk); #1;
        b.nonce_j = n1; b.nonce_t = n2; b.blocks_j = 8'd1; b.blocks_t = 8'd1;
        b.req_j = 1'b1; b.req_t = 1'b1;
        push(0, 1'b0, ks_fn(n1, 1, 2'd0)); push(1, 1'b0, '0);
        push(0, 1'b1, ks_fn(n2, 1, 2'd1)); push(1, 1'b1, '0);
        fork
            wait_end(1'b0, 200);
            wait_end(1'b1, 400);
        join

        // Zero-block TAJNY job
        @(posedge clk); #1;
        b.blocks_t = 8'd0; b.req_t = 1'b1;
        push(2, 1'b1, '0);
        s0 = n_start;
        @(negedge clk);
        @(negedge clk);
        check("t3_err_t", 128'(b.err_t), 128'(1));
        check("t3_aes_reset", 128'(b.aes_reset), 128'(1));
        b.req_t = 1'b0;
        @(negedge clk);
        check("t3_no_start", 128'(n_start - s0), 128'(0));
        check("t3_busy_low", 128'(b.busy), 128'(0));

        // Encrypter never answers
        hang = 1'b1;
        @(posedge clk); #1;
        b.blocks_j = 8'd1; b.req_j = 1'b1;
        push(2, 1'b0, '0);
        wait_start(10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b.err_j && n < TMO + 10);
        check("t4_timeout_cycles", 128'(n), 128'(TMO + 1));
        check("t4_aes_reset", 128'(b.aes_reset), 128'(1));
        b.req_j = 1'b0;
        @(negedge clk);
        check("t4_busy_low", 128'(b.busy), 128'(0));
        hang = 1'b0;

        // Owner drops request mid-WAIT: nothing delivered, no done, no err
        @(posedge clk); #1;
        b.nonce_j = 96'h55; b.blocks_j = 8'd2; b.req_j = 1'b1;
        wait_start(10);
        @(negedge clk);
        b.req_j = 1'b0;
        n = 0;
        while (b.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_idle_after_drop", 128'(b.busy), 128'(0));

        // Reset during WAIT, then a fresh job
        @(posedge clk); #1;
        b.nonce_j = 96'hDEAD; b.blocks_j = 8'd2; b.req_j = 1'b1;
        wait_start(10);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_strobes_zero", out_vec(), '0);
        check("t6_ctr_zero", 128'(b.aes_ctr), '0);
        check("t6_ks_data_zero", b.ks_data, '0);
        b.req_j = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n1 = 96'hBEEF_0000_0000_0000_0000_0001;
        @(posedge clk); #1;
        b.nonce_j = n1; b.blocks_j = 8'd1; b.req_j = 1'b1;
        push(0, 1'b0, ks_fn(n1, 1, 2'd0)); push(1, 1'b0, '0);
        wait_start(10);
        check("t6_ctr_restart", 128'(b.aes_ctr), 128'(1));
        wait_end(1'b0, 200);

        // Narrow counter: refuse to wrap
        @(posedge clk); #1;
        b2.blocks_j = 8'd4; b2.nonce_j = 96'h7; b2.req_j = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(b2.done_j || b2.err_j) && n < 200) begin
            @(negedge clk);
            n++;
        end
        b2.req_j = 1'b0;
        repeat (2) @(negedge clk);
        check("t7_blocks", 128'(n2_ks), 128'(3));
        check("t7_err", 128'(n2_err), 128'(1));
        check("t7_no_done", 128'(n2_done), 128'(0));

        repeat (3) @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck required finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
